// File: rtl/key_debounce.sv
// Debounces one active-low push-button into a clean level plus press, release and
// long-press pulses. All timing is counted in sys_clk cycles.
module key_debounce #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = CLK_FREQ / 50,
  parameter int unsigned LONG_CYC     = CLK_FREQ
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressFilt,
    StPressed,
    StRelFilt
  } state_e;

  state_e            state_q;
  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_done_q;
  logic              key_s;

  assign key_s = sync_q[1];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_in};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!key_s) begin
            state_q  <= StPressFilt;
            db_cnt_q <= '0;
          end
        end
        StPressFilt: begin
          if (key_s) begin
            state_q  <= StIdle;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_MAX) begin
            state_q     <= StPressed;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_press   <= 1'b1;
            key_level   <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        StPressed: begin
          // Saturate at the threshold; long_done_q suppresses repeat pulses.
          if (hold_cnt_q == HOLD_MAX) begin
            if (!long_done_q) begin
              key_long    <= 1'b1;
              long_done_q <= 1'b1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
          if (key_s) begin
            state_q  <= StRelFilt;
            db_cnt_q <= '0;
          end
        end
        StRelFilt: begin
          // Hold count stays frozen so a bounce only delays the long press.
          if (!key_s) begin
            state_q  <= StPressed;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_MAX) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYC=8, LONG_CYC=40.
module tb_key_debounce;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int checks = 0;
  int failures = 0;

  int edge_cnt = 0;
  int n_press = 0, n_release = 0, n_long = 0, n_multi = 0;
  int t_press = 0, t_release = 0, t_long = 0;
  logic lvl_at_press = 1'b0, lvl_at_release = 1'b1;

  key_debounce #(
    .CLK_FREQ    (400),
    .DEBOUNCE_CYC(8),
    .LONG_CYC    (40)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (key_press) begin
      n_press      <= n_press + 1;
      t_press      <= edge_cnt;
      lvl_at_press <= key_level;
    end
    if (key_release) begin
      n_release      <= n_release + 1;
      t_release      <= edge_cnt;
      lvl_at_release <= key_level;
    end
    if (key_long) begin
      n_long <= n_long + 1;
      t_long <= edge_cnt;
    end
    if ((int'(key_press) + int'(key_release) + int'(key_long)) > 1) n_multi <= n_multi + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_in = 1'b1;
    wait_cycles(3);
    checks++;
    if ({key_level, key_press, key_release, key_long} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000",
               {key_level, key_press, key_release, key_long});
    end
    @(negedge sys_clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wait_cycles(1);
      checks++;
      if ({key_level, key_press, key_release, key_long} !== 4'b0) begin
        failures++;
        $display("FAIL idle_outputs cycle=%0d got=%b want=0000", i,
                 {key_level, key_press, key_release, key_long});
      end
    end
  endtask

  task automatic test_press_release;
    int t0, bp, br;
    bp = n_press;
    br = n_release;
    @(negedge sys_clk);
    key_in = 1'b0;
    t0 = edge_cnt;
    wait_cycles(20);
    checks++;
    if (n_press - bp !== 1) begin
      failures++;
      $display("FAIL press_count got=%0d want=1", n_press - bp);
    end
    checks++;
    if (t_press - t0 - 1 !== 10) begin
      failures++;
      $display("FAIL press_latency got=%0d want=10", t_press - t0 - 1);
    end
    checks++;
    if (lvl_at_press !== 1'b1 || key_level !== 1'b1) begin
      failures++;
      $display("FAIL press_level got=%b/%b want=1/1", lvl_at_press, key_level);
    end
    @(negedge sys_clk);
    key_in = 1'b1;
    t0 = edge_cnt;
    wait_cycles(20);
    checks++;
    if (n_release - br !== 1) begin
      failures++;
      $display("FAIL release_count got=%0d want=1", n_release - br);
    end
    checks++;
    if (t_release - t0 - 1 !== 10) begin
      failures++;
      $display("FAIL release_latency got=%0d want=10", t_release - t0 - 1);
    end
    checks++;
    if (lvl_at_release !== 1'b0 || key_level !== 1'b0) begin
      failures++;
      $display("FAIL release_level got=%b/%b want=0/0", lvl_at_release, key_level);
    end
  endtask

  task automatic test_bounce;
    int t0, bp, br;
    bp = n_press;
    br = n_release;
    @(negedge sys_clk); key_in = 1'b0;
    repeat (5) @(negedge sys_clk);
    key_in = 1'b1;
    repeat (2) @(negedge sys_clk);
    key_in = 1'b0;
    repeat (6) @(negedge sys_clk);
    key_in = 1'b1;
    wait_cycles(20);
    checks++;
    if (n_press - bp !== 0 || n_release - br !== 0 || key_level !== 1'b0) begin
      failures++;
      $display("FAIL bounce_quiet got=press%0d/rel%0d/lvl%b want=0/0/0",
               n_press - bp, n_release - br, key_level);
    end
    @(negedge sys_clk);
    key_in = 1'b0;
    t0 = edge_cnt;
    wait_cycles(20);
    checks++;
    if (n_press - bp !== 1 || t_press - t0 - 1 !== 10) begin
      failures++;
      $display("FAIL bounce_then_press got=count%0d/lat%0d want=1/10",
               n_press - bp, t_press - t0 - 1);
    end
    @(negedge sys_clk); key_in = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_long_press;
    int bp, br, bl;
    bp = n_press;
    br = n_release;
    bl = n_long;
    @(negedge sys_clk); key_in = 1'b0;
    wait_cycles(100);
    checks++;
    if (n_press - bp !== 1 || n_long - bl !== 1) begin
      failures++;
      $display("FAIL long_counts got=press%0d/long%0d want=1/1", n_press - bp, n_long - bl);
    end
    checks++;
    if (t_long - t_press !== 40) begin
      failures++;
      $display("FAIL long_latency got=%0d want=40", t_long - t_press);
    end
    @(negedge sys_clk); key_in = 1'b1;
    wait_cycles(20);
    checks++;
    if (n_release - br !== 1 || n_long - bl !== 1 || key_level !== 1'b0) begin
      failures++;
      $display("FAIL long_release got=rel%0d/long%0d/lvl%b want=1/1/0",
               n_release - br, n_long - bl, key_level);
    end
  endtask

  task automatic test_release_glitch;
    int br, bl;
    br = n_release;
    bl = n_long;
    @(negedge sys_clk); key_in = 1'b0;
    repeat (20) @(negedge sys_clk);
    key_in = 1'b1;
    repeat (4) @(negedge sys_clk);
    key_in = 1'b0;
    wait_cycles(60);
    checks++;
    if (n_release - br !== 0 || key_level !== 1'b1) begin
      failures++;
      $display("FAIL glitch_no_release got=rel%0d/lvl%b want=0/1", n_release - br, key_level);
    end
    checks++;
    if (n_long - bl !== 1 || t_long - t_press !== 44) begin
      failures++;
      $display("FAIL glitch_long_delay got=count%0d/lat%0d want=1/44",
               n_long - bl, t_long - t_press);
    end
    @(negedge sys_clk); key_in = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_reset_mid_press;
    int t0, bp, br;
    @(negedge sys_clk); key_in = 1'b0;
    wait_cycles(20);
    bp = n_press;
    br = n_release;
    @(negedge sys_clk); rst = 1'b1;
    @(negedge sys_clk); rst = 1'b0;
    t0 = edge_cnt;
    #1;
    checks++;
    if ({key_level, key_press, key_release, key_long} !== 4'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b want=0000",
               {key_level, key_press, key_release, key_long});
    end
    wait_cycles(20);
    checks++;
    if (n_press - bp !== 1 || t_press - t0 - 1 !== 10 || key_level !== 1'b1) begin
      failures++;
      $display("FAIL rst_repress got=count%0d/lat%0d/lvl%b want=1/10/1",
               n_press - bp, t_press - t0 - 1, key_level);
    end
    checks++;
    if (n_release - br !== 0) begin
      failures++;
      $display("FAIL rst_no_release got=%0d want=0", n_release - br);
    end
    @(negedge sys_clk); key_in = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_exclusive;
    checks++;
    if (n_multi !== 0) begin
      failures++;
      $display("FAIL pulse_exclusive got=%0d want=0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_reset_mid_press();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
